regfile_param: RTL



---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_param_pc_gen.sv | 48 ++++
 rtl/regfile_param.sv | 129 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and byte-merge helper for the parametrised register file.
// Latency: none (package only).
// Backpressure: none.
package regfile_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_NUM_RD  = 2;
    localparam int DEF_PC_IDX  = 15;
    localparam int DEF_LR_IDX  = 14;
    localparam int DEF_PC_STEP = 4;

    // One byte lane of a byte-enabled write: take the new byte only when enabled.
    function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       en);
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/regfile_param_pc_gen.sv
// Program counter with stall > PC write > branch > sequential priority; also emits the link value.
// Latency: new PC visible one cycle after the controlling inputs.
// Backpressure: stall holds the PC; nothing else is blocked.
module pc_gen
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PC_STEP = DEF_PC_STEP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              pc_we,
    input  logic [DATA_W-1:0] wd,
    input  logic              ib,
    input  logic [DATA_W-1:0] bv,
    output logic [DATA_W-1:0] iaddrout,
    output logic [DATA_W-1:0] link_val
);

    localparam logic [DATA_W-1:0] STEP = DATA_W'(PC_STEP);

    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q + STEP;
        if (stall) begin
            pc_d = pc_q;
        end else if (pc_we) begin
            pc_d = wd;
        end else if (ib) begin
            pc_d = bv;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign iaddrout = pc_q;
    assign link_val = pc_q + STEP;

endmodule

// File: rtl/regfile_param.sv
// Architectural register file with byte-enabled writes, link capture and aliased PC; REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
// Latency: reads registered, 1 cycle; writes visible to reads one cycle later.
// Backpressure: none; stall freezes only the PC, register writes always land.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NUM_RD  = DEF_NUM_RD,
    parameter int PC_IDX  = DEF_PC_IDX,
    parameter int LR_IDX  = DEF_LR_IDX,
    parameter int PC_STEP = DEF_PC_STEP
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [DATA_W/8-1:0]      wbe,
    input  logic                     ib,
    input  logic [DATA_W-1:0]        bv,
    input  logic                     bl,
    input  logic                     stall,
    output logic [DATA_W-1:0]        iaddrout
);

    localparam int                NREG  = 2 ** ADDR_W;
    localparam int                NB    = DATA_W / 8;
    localparam logic [ADDR_W-1:0] PC_A  = ADDR_W'(PC_IDX);
    localparam logic [ADDR_W-1:0] LR_A  = ADDR_W'(LR_IDX);
    localparam logic [DATA_W-1:0] STEP2 = DATA_W'(2 * PC_STEP);

    generate
        if (PC_IDX < 0 || LR_IDX < 0 || PC_IDX >= NREG || LR_IDX >= NREG ||
            PC_IDX == LR_IDX || (DATA_W % 8) != 0 || NUM_RD < 1) begin : g_param_err
            $error("regfile_param: illegal PC_IDX/LR_IDX/DATA_W/NUM_RD combination");
        end
    endgenerate

    logic [DATA_W-1:0] regs [NREG];
    logic              pc_we;
    logic              gen_we;
    logic              link;
    logic [DATA_W-1:0] link_val;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] pc_plus2;

    assign pc_we    = we && (wa == PC_A);
    assign gen_we   = we && (wa != PC_A);
    assign link     = ib && bl;
    assign pc_plus2 = iaddrout + STEP2;

    pc_gen #(
        .DATA_W  (DATA_W),
        .PC_STEP (PC_STEP)
    ) u_pc_gen (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .pc_we    (pc_we),
        .wd       (wd),
        .ib       (ib),
        .bv       (bv),
        .iaddrout (iaddrout),
        .link_val (link_val)
    );

    // Byte-merged image of the target register; shared by the write path and the bypass.
    always_comb begin
        merged = regs[wa];
        for (int b = 0; b < NB; b++) begin
            merged[b*8 +: 8] = merge_byte(regs[wa][b*8 +: 8], wd[b*8 +: 8], wbe[b]);
        end
    end

    // Link assignment comes last so it overrides a same-cycle write to LR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (gen_we) begin
                regs[wa] <= merged;
            end
            if (link) begin
                regs[LR_A] <= link_val;
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] rval;
            logic [DATA_W-1:0] q;

            assign ra = rd_addr[k*ADDR_W +: ADDR_W];

            always_comb begin
                rval = regs[ra];
`ifdef REGFILE_BYPASS_EN
                if (gen_we && (wa == ra)) begin
                    rval = merged;
                end
                if (link && (ra == LR_A)) begin
                    rval = link_val;
                end
`endif
                if (ra == PC_A) begin
                    rval = pc_plus2;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    q <= '0;
                end else begin
                    q <= rval;
                end
            end

            assign rd_data[k*DATA_W +: DATA_W] = q;
        end
    endgenerate

endmodule
